// File: rtl/pong_motion_ctrl_pkg.sv
// Shared geometry constants and phase encodings for the pong motion controller.
// The renderer imports the same package so both sides agree on the playfield.
package pong_motion_ctrl_pkg;

    localparam logic [9:0] MAX_X       = 10'd640;
    localparam logic [9:0] MAX_Y       = 10'd480;
    localparam logic [9:0] WALL_X_R    = 10'd35;
    localparam logic [9:0] BAR_X_L     = 10'd580;
    localparam logic [9:0] BAR_X_R     = 10'd583;
    localparam logic [9:0] BAR_Y_SIZE  = 10'd72;
    localparam logic [9:0] BAR_V       = 10'd4;
    localparam logic [9:0] BALL_SIZE   = 10'd8;
    localparam logic [9:0] BALL_V      = 10'd2;
    localparam logic [9:0] BALL_X0     = 10'd300;
    localparam logic [9:0] BALL_Y0     = 10'd236;
    localparam logic [5:0] MISS_FRAMES = 6'd60;
    localparam logic [1:0] LIVES       = 2'd3;

    localparam logic [9:0] BAR_Y_MAX   = MAX_Y - BAR_Y_SIZE;
    localparam logic [9:0] BAR_Y_RST   = (MAX_Y - BAR_Y_SIZE) / 2;

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_MISS  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

endpackage

// File: rtl/pong_paddle_step.sv
// Next paddle top row from the buttons, clamped to the visible field.
module pong_paddle_step
    import pong_motion_ctrl_pkg::*;
(
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [9:0] bar_y,
    output logic [9:0] bar_y_next
);

    always_comb begin
        bar_y_next = bar_y;
        if (btn_down && !btn_up) begin
            bar_y_next = (bar_y >= BAR_Y_MAX - BAR_V) ? BAR_Y_MAX : bar_y + BAR_V;
        end else if (btn_up && !btn_down) begin
            // Clamp before subtracting so the unsigned row never wraps.
            bar_y_next = (bar_y <= BAR_V) ? 10'd0 : bar_y - BAR_V;
        end
    end

endmodule

// File: rtl/pong_motion_ctrl.sv
// Per-frame pong game controller: paddle, ball, score, lives and game phase.
// All state advances only on refr_tick; outputs are the registered state.
module pong_motion_ctrl
    import pong_motion_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       refr_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_serve,
    output logic [9:0] bar_y_t,
    output logic [9:0] ball_x_l,
    output logic [9:0] ball_y_t,
    output logic       ball_visible,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] state
);

    logic       dir_x_right, dir_y_down;
    logic [5:0] miss_cnt;

    logic [9:0] bar_d, ball_x_d, ball_y_d, bar_step;
    logic [9:0] ball_x_r, ball_y_b;
    logic       dir_x_d, dir_y_d, vis_d, hit;
    logic [7:0] score_d;
    logic [1:0] lives_d, state_d;
    logic [5:0] miss_cnt_d;

    pong_paddle_step u_paddle_step (
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .bar_y      (bar_y_t),
        .bar_y_next (bar_step)
    );

    assign ball_x_r = ball_x_l + BALL_SIZE - 10'd1;
    assign ball_y_b = ball_y_t + BALL_SIZE - 10'd1;
    assign hit = (ball_x_r >= BAR_X_L) && (ball_x_r <= BAR_X_R) &&
                 (ball_y_b >= bar_y_t) && (ball_y_t <= bar_y_t + BAR_Y_SIZE - 10'd1) &&
                 dir_x_right;

    always_comb begin
        bar_d      = (state == ST_OVER) ? bar_y_t : bar_step;
        ball_x_d   = ball_x_l;
        ball_y_d   = ball_y_t;
        dir_x_d    = dir_x_right;
        dir_y_d    = dir_y_down;
        vis_d      = ball_visible;
        score_d    = score;
        lives_d    = lives;
        state_d    = state;
        miss_cnt_d = miss_cnt;

        case (state)
            ST_SERVE: begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                dir_x_d  = 1'b1;
                dir_y_d  = 1'b1;
                vis_d    = 1'b1;
                if (btn_serve) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (ball_x_r >= MAX_X - 10'd1 - BALL_V) begin
                    state_d    = ST_MISS;
                    lives_d    = lives - 2'd1;
                    vis_d      = 1'b0;
                    miss_cnt_d = 6'd0;
                end else begin
                    if (ball_y_t <= BALL_V) begin
                        dir_y_d = 1'b1;
                    end else if (ball_y_b >= MAX_Y - 10'd1 - BALL_V) begin
                        dir_y_d = 1'b0;
                    end
                    if (ball_x_l <= WALL_X_R + BALL_V) begin
                        dir_x_d = 1'b1;
                    end else if (hit) begin
                        dir_x_d = 1'b0;
                        if (score != 8'hff) score_d = score + 8'd1;
                    end
                    ball_x_d = dir_x_d ? ball_x_l + BALL_V : ball_x_l - BALL_V;
                    ball_y_d = dir_y_d ? ball_y_t + BALL_V : ball_y_t - BALL_V;
                end
            end
            ST_MISS: begin
                miss_cnt_d = miss_cnt + 6'd1;
                if (miss_cnt == MISS_FRAMES - 6'd1) begin
                    if (lives == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d  = ST_SERVE;
                        ball_x_d = BALL_X0;
                        ball_y_d = BALL_Y0;
                        dir_x_d  = 1'b1;
                        dir_y_d  = 1'b1;
                        vis_d    = 1'b1;
                    end
                end
            end
            default: begin
                vis_d = 1'b0;
                if (btn_serve) begin
                    state_d  = ST_SERVE;
                    score_d  = 8'd0;
                    lives_d  = LIVES;
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b1;
                    vis_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_SERVE;
            bar_y_t      <= BAR_Y_RST;
            ball_x_l     <= BALL_X0;
            ball_y_t     <= BALL_Y0;
            dir_x_right  <= 1'b1;
            dir_y_down   <= 1'b1;
            score        <= 8'd0;
            lives        <= LIVES;
            ball_visible <= 1'b1;
            game_over    <= 1'b0;
            miss_cnt     <= 6'd0;
        end else if (refr_tick) begin
            state        <= state_d;
            bar_y_t      <= bar_d;
            ball_x_l     <= ball_x_d;
            ball_y_t     <= ball_y_d;
            dir_x_right  <= dir_x_d;
            dir_y_down   <= dir_y_d;
            score        <= score_d;
            lives        <= lives_d;
            ball_visible <= vis_d;
            game_over    <= (state_d == ST_OVER);
            miss_cnt     <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Self-checking bench for pong_motion_ctrl: directed game scenarios plus
// randomized ticks/buttons against an integer model of the game rules.
module tb_pong_motion_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       refr_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_serve = 1'b0;
    logic [9:0] bar_y_t, ball_x_l, ball_y_t;
    logic       ball_visible, game_over;
    logic [7:0] score;
    logic [1:0] lives, state;

    int total = 0;
    int bad = 0;

    // Reference model state; directions are +1 / -1.
    int m_bar, m_bx, m_by, m_dx, m_dy, m_score, m_lives, m_state, m_vis, m_cnt;

    pong_motion_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .refr_tick    (refr_tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_serve    (btn_serve),
        .bar_y_t      (bar_y_t),
        .ball_x_l     (ball_x_l),
        .ball_y_t     (ball_y_t),
        .ball_visible (ball_visible),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over),
        .state        (state)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_recentre();
        m_bx = 300; m_by = 236; m_dx = 1; m_dy = 1; m_vis = 1;
    endtask

    task automatic model_reset();
        m_bar = 204; m_score = 0; m_lives = 3; m_state = 0; m_cnt = 0;
        model_recentre();
    endtask

    task automatic model_tick(input bit up, input bit down, input bit serve);
        bit hit;
        if (m_state != 3) begin
            if (down && !up) m_bar = (m_bar + 4 > 408) ? 408 : m_bar + 4;
            else if (up && !down) m_bar = (m_bar < 4) ? 0 : m_bar - 4;
        end
        case (m_state)
            0: begin
                model_recentre();
                if (serve) m_state = 1;
            end
            1: begin
                if (m_bx + 7 >= 637) begin
                    m_state = 2; m_lives--; m_vis = 0; m_cnt = 0;
                end else begin
                    hit = (m_bx + 7 >= 580) && (m_bx + 7 <= 583) && (m_by + 7 >= m_bar) &&
                          (m_by <= m_bar + 71) && (m_dx == 1);
                    if (m_by <= 2) m_dy = 1;
                    else if (m_by + 7 >= 477) m_dy = -1;
                    if (m_bx <= 37) m_dx = 1;
                    else if (hit) begin
                        m_dx = -1;
                        if (m_score < 255) m_score++;
                    end
                    m_bx += 2 * m_dx;
                    m_by += 2 * m_dy;
                end
            end
            2: begin
                m_cnt++;
                if (m_cnt == 60) begin
                    if (m_lives == 0) m_state = 3;
                    else begin
                        m_state = 0;
                        model_recentre();
                    end
                end
            end
            default: begin
                m_vis = 0;
                if (serve) begin
                    m_state = 0; m_score = 0; m_lives = 3;
                    model_recentre();
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("bar_y_t", int'(bar_y_t), m_bar);
        check_eq("ball_x_l", int'(ball_x_l), m_bx);
        check_eq("ball_y_t", int'(ball_y_t), m_by);
        check_eq("ball_visible", int'(ball_visible), m_vis);
        check_eq("score", int'(score), m_score);
        check_eq("lives", int'(lives), m_lives);
        check_eq("state", int'(state), m_state);
        check_eq("game_over", int'(game_over), (m_state == 3) ? 1 : 0);
    endtask

    task automatic step(input bit tick, input bit up, input bit down, input bit serve,
                        input bit rst);
        refr_tick = tick; btn_up = up; btn_down = down; btn_serve = serve; RST = rst;
        @(posedge CLK);
        if (rst) model_reset();
        else if (tick) model_tick(up, down, serve);
        #1;
        compare_all();
    endtask

    // Irregular frame spacing: idle cycles with noisy buttons before each tick.
    task automatic do_tick(input bit up, input bit down, input bit serve);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        step(1'b1, up, down, serve, 1'b0);
    endtask

    initial begin
        int n;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_bar", int'(bar_y_t), 204);
        check_eq("rst_ball_x", int'(ball_x_l), 300);
        check_eq("rst_ball_y", int'(ball_y_t), 236);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_lives", int'(lives), 3);
        check_eq("rst_vis", int'(ball_visible), 1);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1, 1'b0);
        check_eq("bar_first_down", int'(bar_y_t), 208);
        for (int i = 1; i < 60; i++) do_tick(1'b0, 1'b1, 1'b0);
        check_eq("bar_clamp_hi", int'(bar_y_t), 408);
        for (int i = 0; i < 110; i++) do_tick(1'b1, 1'b0, 1'b0);
        check_eq("bar_clamp_lo", int'(bar_y_t), 0);
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1, 1'b0);
        check_eq("bar_both_hold", int'(bar_y_t), 0);
        for (int i = 0; i < 102; i++) do_tick(1'b0, 1'b1, 1'b0);
        check_eq("bar_park_hi", int'(bar_y_t), 408);

        do_tick(1'b0, 1'b0, 1'b1);
        check_eq("serve_state", int'(state), 1);
        check_eq("serve_no_move", int'(ball_x_l), 300);
        do_tick(1'b0, 1'b0, 1'b0);
        check_eq("first_move_x", int'(ball_x_l), 302);
        check_eq("first_move_y", int'(ball_y_t), 238);
        n = 0;
        while (m_score == 0 && n < 400) begin
            do_tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check_eq("hit_x", int'(ball_x_l), 572);
        check_eq("hit_score", int'(score), 1);

        for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("midplay_rst_state", int'(state), 0);
        check_eq("midplay_rst_score", int'(score), 0);
        check_eq("midplay_rst_bar", int'(bar_y_t), 204);

        for (int i = 0; i < 51; i++) do_tick(1'b1, 1'b0, 1'b0);
        check_eq("bar_park_lo", int'(bar_y_t), 0);
        for (int k = 0; k < 3; k++) begin
            do_tick(1'b0, 1'b0, 1'b1);
            n = 0;
            while (m_state != 2 && n < 400) begin
                do_tick(1'b0, 1'b0, 1'b0);
                n++;
            end
            check_eq("miss_state", int'(state), 2);
            check_eq("miss_vis", int'(ball_visible), 0);
            check_eq("miss_lives", int'(lives), 2 - k);
            for (int i = 0; i < 59; i++) do_tick(1'b0, 1'b0, 1'b0);
            check_eq("miss_hold", int'(state), 2);
            do_tick(1'b0, 1'b0, 1'b0);
            if (k < 2) begin
                check_eq("respawn_state", int'(state), 0);
                check_eq("respawn_x", int'(ball_x_l), 300);
                check_eq("respawn_y", int'(ball_y_t), 236);
            end else begin
                check_eq("over_state", int'(state), 3);
                check_eq("over_flag", int'(game_over), 1);
                check_eq("over_lives", int'(lives), 0);
            end
        end
        do_tick(1'b0, 1'b0, 1'b1);
        check_eq("restart_state", int'(state), 0);
        check_eq("restart_lives", int'(lives), 3);
        check_eq("restart_score", int'(score), 0);

        for (int i = 0; i < 8000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2999) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
